// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, load/store funct3 encodings
// and the LSU state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Loads reject 011/110/111; stores only accept B/H/W.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3[2] | (f3[1:0] == 2'b11);
        end
        return (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU: store lane replication and byte
// enables, load extraction with sign/zero extension, and legality checks.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate the datum into every lane it may occupy and
    // enable only the lanes the access touches.
    always_comb begin
        wdata_o      = wdata_i;
        be_o         = 4'b0000;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {(XLEN/8){wdata_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
            end
            2'b01: begin
                wdata_o      = {(XLEN/16){wdata_i[15:0]}};
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
        illegal_o = f3_illegal(we_i, funct3_i);
    end

    assign ld_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Load side: pick the addressed lane and extend it to full width.
    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, ld_byte};
            F3_H:    rdata_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, ld_half};
            F3_W:    rdata_o = rdata_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit behind the execute stage. Runs a req/gnt/rvalid handshake
// with data memory and returns extended load data plus a fault flag.
// Optional watchdog: define LSU_TIMEOUT_EN to fault accesses that stall in
// REQ/WAIT for TIMEOUT_CYCLES cycles.
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN           = riscv_pkg::XLEN,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            busy,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      addr_lo_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [3:0]      mem_be_q;
    logic            rsp_valid_q;
    logic            rsp_fault_q;
    logic [XLEN-1:0] rsp_rdata_q;

    logic            sel_we;
    logic [2:0]      sel_f3;
    logic [1:0]      sel_addr_lo;
    logic [XLEN-1:0] al_wdata;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_rdata;
    logic            al_misaligned;
    logic            al_illegal;
    logic            timeout_hit;

    // The aligner sees the incoming request while idle (legality and store
    // lanes) and the captured request afterwards (load extraction).
    assign sel_we      = (state_q == IDLE) ? req_we          : we_q;
    assign sel_f3      = (state_q == IDLE) ? req_funct3      : f3_q;
    assign sel_addr_lo = (state_q == IDLE) ? req_addr[1:0]   : addr_lo_q;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .we_i        (sel_we),
        .funct3_i    (sel_f3),
        .addr_lo_i   (sel_addr_lo),
        .wdata_i     (req_wdata),
        .rdata_i     (mem_rdata),
        .wdata_o     (al_wdata),
        .be_o        (al_be),
        .rdata_o     (al_rdata),
        .misaligned_o(al_misaligned),
        .illegal_o   (al_illegal)
    );

`ifdef LSU_TIMEOUT_EN
    logic [31:0] cnt_q;

    // Cycles spent in REQ/WAIT; held at zero while idle so it starts clean.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign timeout_hit = (cnt_q >= TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Access sequencer with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= F3_B;
            addr_lo_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (al_illegal || al_misaligned) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata_q <= al_wdata;
                            mem_be_q    <= al_be;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt && (we_q || mem_rvalid)) begin
                        // Store done, or load data returned with the grant.
                        mem_req_q   <= 1'b0;
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : al_rdata;
                    end else if (timeout_hit) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= al_rdata;
                    end else if (timeout_hit) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
